// File: rtl/fp_add_sub_pipe_if.sv
// Handshake/data bundle for fp_add_sub_pipe: operand request side and
// result side with exception flags.
interface fp_add_sub_pipe_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic         valid_in;
  logic         in_ready;
  logic [W-1:0] dina;
  logic [W-1:0] dinb;
  logic         op;
  logic [W-1:0] result;
  logic         valid_out;
  logic         out_ready;
  logic         flag_invalid;
  logic         flag_overflow;
  logic         flag_underflow;
  logic         flag_inexact;

  modport master (
    output valid_in, dina, dinb, op, out_ready,
    input  in_ready, result, valid_out,
           flag_invalid, flag_overflow, flag_underflow, flag_inexact
  );

  modport slave (
    input  valid_in, dina, dinb, op, out_ready,
    output in_ready, result, valid_out,
           flag_invalid, flag_overflow, flag_underflow, flag_inexact
  );
endinterface

// File: rtl/fp_add_sub_pipe.sv
// Four-stage pipelined IEEE-754-style add/sub, RNE rounding, global stall.
// Define FPADD_SUBNORMAL_EN for gradual underflow; otherwise flush-to-zero.
module fp_add_sub_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input logic              clk,
  input logic              rst,
  fp_add_sub_pipe_if.slave bus
);
  localparam int          W     = 1 + EXP_W + MAN_W;
  localparam int          XW    = MAN_W + 4;
  localparam int          SW    = MAN_W + 5;
  localparam int          LZW   = $clog2(SW + 1);
  localparam int unsigned SHMAX = MAN_W + 3;
  localparam int          EMAX  = (1 << EXP_W) - 1;
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef struct packed {
    logic             nan;
    logic             inf;
    logic [EXP_W-1:0] e;
    logic [MAN_W:0]   m;
  } dec_t;

  typedef struct packed {
    logic             sx;
    logic             sy;
    logic [EXP_W-1:0] ex;
    logic [MAN_W:0]   mx;
    logic [MAN_W:0]   my;
    logic [EXP_W-1:0] diff;
    logic             spec;
    logic             inv;
    logic [W-1:0]     spec_res;
  } s1_t;

  typedef struct packed {
    logic             sx;
    logic             zsign;
    logic             eff_sub;
    logic [EXP_W-1:0] ex;
    logic [XW-1:0]    x_ext;
    logic [XW-1:0]    y_al;
    logic             spec;
    logic             inv;
    logic [W-1:0]     spec_res;
  } s2_t;

  typedef struct packed {
    logic             sx;
    logic             zsign;
    logic [EXP_W-1:0] ex;
    logic [SW-1:0]    sum;
    logic [LZW-1:0]   lz;
    logic             spec;
    logic             inv;
    logic [W-1:0]     spec_res;
  } s3_t;

  typedef struct packed {
    logic         valid;
    logic [W-1:0] result;
    logic         inv;
    logic         ovf;
    logic         unf;
    logic         inx;
  } out_t;

  // Zero and subnormal fields share effective exponent 1 so alignment needs no special case.
  function automatic dec_t decode(input logic [W-1:0] v);
    dec_t             d;
    logic [EXP_W-1:0] e;
    logic [MAN_W-1:0] f;
    e     = v[W-2 -: EXP_W];
    f     = v[MAN_W-1:0];
    d.nan = (&e) && (|f);
    d.inf = (&e) && !(|f);
    if (e == '0) begin
      d.e = EXP_W'(1);
`ifdef FPADD_SUBNORMAL_EN
      d.m = {1'b0, f};
`else
      d.m = '0;
`endif
    end else begin
      d.e = e;
      d.m = {1'b1, f};
    end
    return d;
  endfunction

  logic        adv;
  logic [3:1]  v_d, v_q;
  s1_t         s1_d, s1_q;
  s2_t         s2_d, s2_q;
  s3_t         s3_d, s3_q;
  out_t        out_d, out_q;

  dec_t        da, db;
  logic        sa, sb, swap;
  logic [XW-1:0] y_ext;
  logic        sticky;
  int unsigned sh;
  int          e, ls;
  logic [XW-1:0]    m;
  logic [MAN_W+1:0] rm;
  logic        rup, inexact;

  always_comb adv = !out_q.valid || bus.out_ready;
  always_comb v_d = {v_q[2:1], bus.valid_in};

  // S1: unpack, classify, order by magnitude.
  always_comb begin
    da   = decode(bus.dina);
    db   = decode(bus.dinb);
    sa   = bus.dina[W-1];
    sb   = bus.dinb[W-1] ^ bus.op;
    swap = {db.e, db.m} > {da.e, da.m};
    s1_d = '0;
    s1_d.sx   = swap ? sb : sa;
    s1_d.sy   = swap ? sa : sb;
    s1_d.ex   = swap ? db.e : da.e;
    s1_d.mx   = swap ? db.m : da.m;
    s1_d.my   = swap ? da.m : db.m;
    s1_d.diff = (swap ? db.e : da.e) - (swap ? da.e : db.e);
    if (da.nan || db.nan) begin
      s1_d.spec     = 1'b1;
      s1_d.spec_res = QNAN;
    end else if (da.inf && db.inf && (sa != sb)) begin
      s1_d.spec     = 1'b1;
      s1_d.inv      = 1'b1;
      s1_d.spec_res = QNAN;
    end else if (da.inf) begin
      s1_d.spec     = 1'b1;
      s1_d.spec_res = {sa, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (db.inf) begin
      s1_d.spec     = 1'b1;
      s1_d.spec_res = {sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end
  end

  // S2: align smaller operand; everything shifted below bit 0 folds into sticky.
  always_comb begin
    sh     = (32'(s1_q.diff) > SHMAX) ? SHMAX : 32'(s1_q.diff);
    y_ext  = {s1_q.my, 3'b000};
    sticky = 1'b0;
    for (int unsigned i = 0; i < XW; i++) begin
      if (i < sh && y_ext[i]) sticky = 1'b1;
    end
    s2_d          = '0;
    s2_d.sx       = s1_q.sx;
    s2_d.zsign    = s1_q.sx & s1_q.sy;
    s2_d.eff_sub  = s1_q.sx ^ s1_q.sy;
    s2_d.ex       = s1_q.ex;
    s2_d.x_ext    = {s1_q.mx, 3'b000};
    s2_d.y_al     = y_ext >> sh;
    s2_d.y_al[0]  = s2_d.y_al[0] | sticky;
    s2_d.spec     = s1_q.spec;
    s2_d.inv      = s1_q.inv;
    s2_d.spec_res = s1_q.spec_res;
  end

  // S3: significand add/sub and leading-zero count.
  always_comb begin
    s3_d          = '0;
    s3_d.sx       = s2_q.sx;
    s3_d.zsign    = s2_q.zsign;
    s3_d.ex       = s2_q.ex;
    s3_d.spec     = s2_q.spec;
    s3_d.inv      = s2_q.inv;
    s3_d.spec_res = s2_q.spec_res;
    if (s2_q.eff_sub) s3_d.sum = {1'b0, s2_q.x_ext} - {1'b0, s2_q.y_al};
    else              s3_d.sum = {1'b0, s2_q.x_ext} + {1'b0, s2_q.y_al};
    s3_d.lz = LZW'(SW);
    for (int unsigned i = 0; i < SW; i++) begin
      if (s3_d.sum[i]) s3_d.lz = LZW'(SW - 1 - i);
    end
  end

  // S4: normalise, round-to-nearest-even, exceptions, repack.
  always_comb begin
    out_d = '0;
    ls    = 0;
    if (s3_q.sum[SW-1]) begin
      m = {s3_q.sum[SW-1:2], |s3_q.sum[1:0]};
      e = int'(s3_q.ex) + 1;
    end else begin
      ls = int'(s3_q.lz) - 1;
`ifdef FPADD_SUBNORMAL_EN
      // Stop at exponent 1 so tiny results come out as subnormals.
      if (ls > int'(s3_q.ex) - 1) ls = int'(s3_q.ex) - 1;
`endif
      m = XW'(s3_q.sum << ls);
      e = int'(s3_q.ex) - ls;
    end
    inexact = |m[2:0];
    rup     = m[2] & (m[1] | m[0] | m[3]);
    rm      = {1'b0, m[XW-1:3]} + {{(MAN_W+1){1'b0}}, rup};
    if (rm[MAN_W+1]) begin
      rm = rm >> 1;
      e  = e + 1;
    end
    out_d.valid = v_q[3];
    if (v_q[3]) begin
      if (s3_q.spec) begin
        out_d.result = s3_q.spec_res;
        out_d.inv    = s3_q.inv;
      end else if (s3_q.sum == '0) begin
        out_d.result = {s3_q.zsign, {(W-1){1'b0}}};
      end else if (e >= EMAX) begin
        out_d.result = {s3_q.sx, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        out_d.ovf    = 1'b1;
        out_d.inx    = 1'b1;
`ifndef FPADD_SUBNORMAL_EN
      end else if (e < 1) begin
        out_d.result = {s3_q.sx, {(W-1){1'b0}}};
        out_d.unf    = 1'b1;
        out_d.inx    = 1'b1;
`endif
      end else begin
        out_d.result = {s3_q.sx, rm[MAN_W] ? EXP_W'(e) : {EXP_W{1'b0}}, rm[MAN_W-1:0]};
        out_d.inx    = inexact;
`ifdef FPADD_SUBNORMAL_EN
        out_d.unf    = !rm[MAN_W] && inexact;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q   <= '0;
      s1_q  <= '0;
      s2_q  <= '0;
      s3_q  <= '0;
      out_q <= '0;
    end else if (adv) begin
      v_q   <= v_d;
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      s3_q  <= s3_d;
      out_q <= out_d;
    end
  end

  assign bus.in_ready       = adv;
  assign bus.valid_out      = out_q.valid;
  assign bus.result         = out_q.result;
  assign bus.flag_invalid   = out_q.inv;
  assign bus.flag_overflow  = out_q.ovf;
  assign bus.flag_underflow = out_q.unf;
  assign bus.flag_inexact   = out_q.inx;
endmodule

// File: tb/tb_fp_add_sub_pipe.sv
// Scoreboard bench for fp_add_sub_pipe (fp32): directed vectors, backpressure,
// mid-stream reset. Honours FPADD_SUBNORMAL_EN for the tiny-result vectors.
module tb_fp_add_sub_pipe;
  localparam logic [3:0] F_NONE = 4'b0000;
  localparam logic [3:0] F_INX  = 4'b0001;
  localparam logic [3:0] F_UNF  = 4'b0010;
  localparam logic [3:0] F_OVF  = 4'b0100;
  localparam logic [3:0] F_INV  = 4'b1000;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  flg;
    int          acc;
    bit          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   fails  = 0;
  int   cyc    = 0;
  exp_t sbq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fp_add_sub_pipe_if #(.EXP_W(8), .MAN_W(23)) bus ();
  fp_add_sub_pipe #(.EXP_W(8), .MAN_W(23)) dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got=%h want=%h", name, got, want);
    end
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic o,
                      input logic [31:0] res, input logic [3:0] flg, input bit lat);
    bit acc;
    int n;
    bus.valid_in = 1'b1;
    bus.dina     = a;
    bus.dinb     = b;
    bus.op       = o;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = bus.in_ready;
      if (acc) sbq.push_back('{res, flg, cyc, lat});
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) check("send_timeout", 64'(0), 64'(1));
    bus.valid_in = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_empty", 64'(sbq.size()), 64'(0));
  endtask

  task automatic monitor();
    exp_t        e;
    logic [3:0]  f;
    forever begin
      @(negedge clk);
      if (!rst && bus.valid_out && bus.out_ready) begin
        f = {bus.flag_invalid, bus.flag_overflow, bus.flag_underflow, bus.flag_inexact};
        if (sbq.size() == 0) begin
          check("unexpected_output", 64'(bus.result), 64'(32'hFFFFFFFF) ^ 64'(bus.result));
        end else begin
          e = sbq.pop_front();
          check("result_flags", {28'd0, bus.result, f}, {28'd0, e.res, e.flg});
          if (e.lat) check("latency", 64'(cyc - e.acc), 64'(4));
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] bp_a [8];
    logic [31:0] bp_b [8];
    logic        bp_o [8];
    logic [31:0] bp_r [8];
    logic [31:0] held;

    rst           = 1'b1;
    bus.valid_in  = 1'b0;
    bus.dina      = '0;
    bus.dinb      = '0;
    bus.op        = 1'b0;
    bus.out_ready = 1'b1;
    fork monitor(); join_none
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("reset_valid_out", 64'(bus.valid_out), 64'(0));
    check("reset_result", 64'(bus.result), 64'(0));
    check("reset_flags", 64'({bus.flag_invalid, bus.flag_overflow, bus.flag_underflow, bus.flag_inexact}), 64'(0));
    check("reset_in_ready", 64'(bus.in_ready), 64'(1));

    send(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, F_NONE, 1'b1);
    wait_drain();
    send(32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, F_NONE, 1'b1);
    wait_drain();

    send(32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, F_NONE, 1'b0);
    send(32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, F_INX,  1'b0);
    send(32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, F_INX,  1'b0);
    send(32'h3FC00000, 32'h3F800000, 1'b1, 32'h3F000000, F_NONE, 1'b0);
    send(32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, F_INV,  1'b0);
    send(32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, F_NONE, 1'b0);
    send(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, F_OVF | F_INX, 1'b0);
    send(32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, F_NONE, 1'b0);
    send(32'h80000000, 32'h80000000, 1'b0, 32'h80000000, F_NONE, 1'b0);
    send(32'h80000000, 32'h00000000, 1'b1, 32'h80000000, F_NONE, 1'b0);
    send(32'h00000000, 32'h80000000, 1'b0, 32'h00000000, F_NONE, 1'b0);
`ifdef FPADD_SUBNORMAL_EN
    send(32'h00800000, 32'h00700000, 1'b1, 32'h00100000, F_NONE, 1'b0);
    send(32'h00800000, 32'h00800001, 1'b1, 32'h80000001, F_NONE, 1'b0);
`else
    send(32'h00800000, 32'h00700000, 1'b1, 32'h00800000, F_NONE, 1'b0);
    send(32'h00800000, 32'h00800001, 1'b1, 32'h80000000, F_UNF | F_INX, 1'b0);
`endif
    wait_drain();

    bp_a = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40A00000,
             32'h41200000, 32'h3F800000, 32'h3F000000, 32'h42C80000};
    bp_b = '{32'h3F800000, 32'h40000000, 32'h3F800000, 32'h3F800000,
             32'h40A00000, 32'h40400000, 32'h3E800000, 32'h42C60000};
    bp_o = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    bp_r = '{32'h40000000, 32'h40800000, 32'h40800000, 32'h40800000,
             32'h41700000, 32'hC0000000, 32'h3F400000, 32'h3F800000};
    held = '0;
    fork
      begin
        for (int i = 0; i < 8; i++) send(bp_a[i], bp_b[i], bp_o[i], bp_r[i], F_NONE, 1'b0);
      end
      begin
        repeat (2) @(posedge clk);
        #1 bus.out_ready = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("bp_in_ready_low", 64'(bus.in_ready), 64'(0));
        check("bp_ops_held", 64'(sbq.size()), 64'(4));
        check("bp_valid_out_held", 64'(bus.valid_out), 64'(1));
        held = bus.result;
        repeat (3) @(posedge clk);
        #1;
        check("bp_result_stable", 64'(bus.result), 64'(held));
        bus.out_ready = 1'b1;
      end
    join
    wait_drain();

    send(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, F_NONE, 1'b0);
    send(32'h40000000, 32'h40000000, 1'b0, 32'h40800000, F_NONE, 1'b0);
    send(32'h40400000, 32'h3F800000, 1'b0, 32'h40800000, F_NONE, 1'b0);
    rst          = 1'b1;
    bus.valid_in = 1'b1;
    bus.dina     = 32'h40A00000;
    bus.dinb     = 32'h40A00000;
    @(posedge clk);
    #1;
    rst          = 1'b0;
    bus.valid_in = 1'b0;
    sbq.delete();
    check("post_reset_in_ready", 64'(bus.in_ready), 64'(1));
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("post_reset_quiet",
            64'({bus.valid_out, bus.result, bus.flag_invalid, bus.flag_overflow,
                 bus.flag_underflow, bus.flag_inexact}), 64'(0));
    end
    @(posedge clk);
    #1;
    send(32'h41200000, 32'h40A00000, 1'b1, 32'h40A00000, F_NONE, 1'b1);
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
